multicycle_controller: RTL and testbench

//   Multi-cycle sequencer for the RV32 datapath: walks each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/riscv_ctrl_pkg.sv | 46 ++++
 rtl/multicycle_controller_if.sv | 44 ++++
 rtl/ctrl_perf_counters.sv | 38 +++
 rtl/multicycle_controller.sv | 176 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// Module : riscv_ctrl_pkg
// Brief  : Opcodes, ALUOp codes, state encoding and decode helpers for the
//          RV32 multi-cycle controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b00;
  localparam logic [1:0] ALUOP_MEM = 2'b01;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  function automatic logic isLegalOp(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Returns {ALUSrc, ALUOp} for a supported opcode.
  function automatic logic [2:0] aluCtrl(input logic [6:0] op);
    logic [2:0] v;
    case (op)
      OP_R:    v = {1'b0, ALUOP_R};
      OP_I:    v = {1'b1, ALUOP_I};
      default: v = {1'b1, ALUOP_MEM};
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module : multicycle_controller_if
// Brief  : Datapath/memory-side signal bundle of the multi-cycle controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic             halt;
  logic [6:0]       instr_opcode;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             dmem_req;
  logic             PCWrite;
  logic             IRWrite;
  logic             ALUSrc;
  logic [1:0]       ALUOp;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             illegal_op;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  halt, instr_opcode, imem_ready, dmem_ready,
    output imem_req, dmem_req, PCWrite, IRWrite, ALUSrc, ALUOp,
           MemRead, MemWrite, MemtoReg, RegWrite, illegal_op,
           cycle_cnt, instret_cnt
  );

  modport slave (
    output halt, instr_opcode, imem_ready, dmem_ready,
    input  imem_req, dmem_req, PCWrite, IRWrite, ALUSrc, ALUOp,
           MemRead, MemWrite, MemtoReg, RegWrite, illegal_op,
           cycle_cnt, instret_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ctrl_perf_counters.sv
// ============================================================================
// Module : ctrl_perf_counters
// Brief  : Free-running cycle counter and retired-instruction counter.
//          Only built when CTRL_PERF_CNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef CTRL_PERF_CNT_EN
module ctrl_perf_counters #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc_ret,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      instret_cnt
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + c_one;
      if (inc_ret) begin
        instret_cnt <= instret_cnt + c_one;
      end
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module : multicycle_controller
// Brief  : RV32 multi-cycle sequencer FETCH/DECODE/EXEC/MEM/WB (+TRAP).
//          Optional performance counters under CTRL_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  multicycle_controller_if.master bus
);

  state_t     r_state;
  logic [6:0] r_opQ;
  logic       r_fetchPend;
  logic       r_aluSrc;
  logic [1:0] r_aluOp;
  logic       r_memRead;
  logic       r_memWrite;
  logic       r_memtoReg;
  logic       r_regWrite;
  logic       r_dmemReq;
  logic       r_illegal;

  logic w_imemReq;
  logic w_fetchDone;
  logic w_isLoad;
  logic w_isStore;

  // Gating with rst_n keeps the fetch request low while reset is held.
  assign w_imemReq   = rst_n && (r_state == S_FETCH) && (r_fetchPend || !bus.halt);
  assign w_fetchDone = w_imemReq && bus.imem_ready;
  assign w_isLoad    = (r_opQ == OP_LOAD);
  assign w_isStore   = (r_opQ == OP_STORE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_opQ       <= '0;
      r_fetchPend <= 1'b0;
      r_aluSrc    <= 1'b0;
      r_aluOp     <= ALUOP_I;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_memtoReg  <= 1'b0;
      r_regWrite  <= 1'b0;
      r_dmemReq   <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_regWrite <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_fetchDone) begin
            r_state     <= S_DECODE;
            r_fetchPend <= 1'b0;
          end else if (w_imemReq) begin
            r_fetchPend <= 1'b1;
          end
        end

        S_DECODE: begin
          r_opQ <= bus.instr_opcode;
          if (isLegalOp(bus.instr_opcode)) begin
            r_state               <= S_EXEC;
            {r_aluSrc, r_aluOp}   <= aluCtrl(bus.instr_opcode);
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end

        S_EXEC: begin
          if (w_isLoad || w_isStore) begin
            r_state    <= S_MEM;
            r_dmemReq  <= 1'b1;
            r_memRead  <= w_isLoad;
            r_memWrite <= w_isStore;
            r_aluSrc   <= 1'b1;
            r_aluOp    <= ALUOP_MEM;
          end else begin
            r_state    <= S_WB;
            r_regWrite <= 1'b1;
            r_memtoReg <= 1'b0;
          end
        end

        S_MEM: begin
          if (bus.dmem_ready) begin
            r_dmemReq  <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            if (w_isLoad) begin
              r_state    <= S_WB;
              r_regWrite <= 1'b1;
              r_memtoReg <= 1'b1;
            end else begin
              r_state  <= S_FETCH;
              r_aluSrc <= 1'b0;
              r_aluOp  <= ALUOP_I;
            end
          end
        end

        S_WB: begin
          r_state    <= S_FETCH;
          r_memtoReg <= 1'b0;
          r_aluSrc   <= 1'b0;
          r_aluOp    <= ALUOP_I;
        end

        S_TRAP: begin
          r_state <= S_TRAP;
        end

        default: begin
          // Unreachable encodings recover to a clean fetch.
          r_state     <= S_FETCH;
          r_fetchPend <= 1'b0;
          r_aluSrc    <= 1'b0;
          r_aluOp     <= ALUOP_I;
          r_memRead   <= 1'b0;
          r_memWrite  <= 1'b0;
          r_memtoReg  <= 1'b0;
          r_dmemReq   <= 1'b0;
          r_illegal   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = w_imemReq;
  assign bus.IRWrite    = w_fetchDone;
  assign bus.PCWrite    = w_fetchDone;
  assign bus.dmem_req   = r_dmemReq;
  assign bus.ALUSrc     = r_aluSrc;
  assign bus.ALUOp      = r_aluOp;
  assign bus.MemRead    = r_memRead;
  assign bus.MemWrite   = r_memWrite;
  assign bus.MemtoReg   = r_memtoReg;
  assign bus.RegWrite   = r_regWrite;
  assign bus.illegal_op = r_illegal;

`ifdef CTRL_PERF_CNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] w_cycleCnt;
  logic [CNT_W-1:0] w_instretCnt;

  assign w_retire = (r_state == S_WB) ||
                    ((r_state == S_MEM) && bus.dmem_ready && w_isStore);

  ctrl_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_ret     (w_retire),
    .cycle_cnt   (w_cycleCnt),
    .instret_cnt (w_instretCnt)
  );

  assign bus.cycle_cnt   = w_cycleCnt;
  assign bus.instret_cnt = w_instretCnt;
`else
  assign bus.cycle_cnt   = {CNT_W{1'b0}};
  assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module : tb_multicycle_controller
// Brief  : Randomized self-checking bench; per-cycle expectations come from an
//          instruction-level phase model of the controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_SYS   = 7'b1110011;

  typedef struct packed {
    logic        halt;
    logic        iRdy;
    logic        dRdy;
    logic [6:0]  opc;
    logic [11:0] exp;
  } cyc_t;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nPass;
  int   expCycles;
  int   expInstret;
  cyc_t        stimQ[$];
  logic [11:0] expQ[$];
  logic [11:0] obsQ[$];

  multicycle_controller_if #(.CNT_W(32)) bus ();

  multicycle_controller #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, IRWrite, PCWrite, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite, dmem_req, illegal_op}
  function automatic logic [11:0] mk(input bit ireq, input bit irw, input bit pcw, input bit src,
                                     input logic [1:0] aop, input bit mr, input bit mw,
                                     input bit m2r, input bit rw, input bit dreq, input bit ill);
    return {ireq, irw, pcw, src, aop, mr, mw, m2r, rw, dreq, ill};
  endfunction

  function automatic logic [11:0] sample();
    return {bus.imem_req, bus.IRWrite, bus.PCWrite, bus.ALUSrc, bus.ALUOp, bus.MemRead,
            bus.MemWrite, bus.MemtoReg, bus.RegWrite, bus.dmem_req, bus.illegal_op};
  endfunction

  function automatic bit rb();
    return ($urandom % 2) == 1;
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic logic [6:0] randOp();
    case ($urandom % 4)
      0:       return T_R;
      1:       return T_I;
      2:       return T_LOAD;
      default: return T_STORE;
    endcase
  endfunction

  task automatic push(input bit h, input bit ir, input bit dr, input logic [6:0] opc,
                      input logic [11:0] e);
    cyc_t c;
    c.halt = h; c.iRdy = ir; c.dRdy = dr; c.opc = opc; c.exp = e;
    stimQ.push_back(c);
    expQ.push_back(e);
  endtask

  task automatic add_fetch(input int iwait);
    for (int i = 0; i <= iwait; i++) begin
      push(1'b0, i == iwait, rb(), junk(), mk(1, i == iwait, i == iwait, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // DECODE onwards for one supported instruction.
  task automatic add_body(input logic [6:0] op, input int dwait);
    bit         src;
    logic [1:0] aop;
    bit         isLd;
    bit         isSt;
    isLd = (op == T_LOAD);
    isSt = (op == T_STORE);
    src  = (op != T_R);
    aop  = (op == T_R) ? 2'b10 : (op == T_I) ? 2'b00 : 2'b01;
    push(rb(), rb(), rb(), op, 12'd0);
    push(rb(), rb(), rb(), junk(), mk(0, 0, 0, src, aop, 0, 0, 0, 0, 0, 0));
    if (isLd || isSt) begin
      for (int i = 0; i <= dwait; i++) begin
        push(rb(), rb(), i == dwait, junk(), mk(0, 0, 0, 1, 2'b01, isLd, isSt, 0, 0, 1, 0));
      end
    end
    if (!isSt) begin
      push(rb(), rb(), rb(), junk(), mk(0, 0, 0, src, aop, 0, 0, isLd, 1, 0, 0));
    end
    expInstret++;
  endtask

  task automatic add_instr(input logic [6:0] op, input int iwait, input int dwait);
    add_fetch(iwait);
    add_body(op, dwait);
  endtask

  // Entered and left at posedge+1.
  task automatic run_stim();
    cyc_t c;
    obsQ.delete();
    while (stimQ.size() > 0) begin
      c = stimQ.pop_front();
      bus.halt         = c.halt;
      bus.imem_ready   = c.iRdy;
      bus.dmem_ready   = c.dRdy;
      bus.instr_opcode = c.opc;
      #1;
      obsQ.push_back(sample());
      @(posedge clk);
      #1;
      expCycles++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.halt = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.instr_opcode = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expCycles  = 0;
    expInstret = 0;
    expQ.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.halt = 1'b0; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; bus.instr_opcode = T_R;
    #3;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (sample() !== 12'd0) $display("FAIL reset_outputs got=%b exp=%b", sample(), 12'd0);
    else nPass++;
    nChecks++;
    if (bus.cycle_cnt !== 32'd0 || bus.instret_cnt !== 32'd0)
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.cycle_cnt, bus.instret_cnt);
    else nPass++;
    do_reset();
  endtask

  task automatic test_rtype();
    expQ.delete();
    add_instr(T_R, 0, 0);
    add_instr(T_I, 0, 0);
    run_stim();
    for (int i = 0; i < expQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i]) $display("FAIL rtype cyc%0d got=%b exp=%b", i, obsQ[i], expQ[i]);
      else nPass++;
    end
  endtask

  task automatic test_load_wait();
    expQ.delete();
    add_instr(T_LOAD, 0, 3);
    add_instr(T_LOAD, int'($urandom % 3), int'($urandom % 4));
    run_stim();
    for (int i = 0; i < expQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i]) $display("FAIL load cyc%0d got=%b exp=%b", i, obsQ[i], expQ[i]);
      else nPass++;
    end
  endtask

  task automatic test_store();
    expQ.delete();
    add_instr(T_STORE, 0, 0);
    add_instr(T_R, 0, 0);
    add_instr(T_STORE, int'($urandom % 3), int'($urandom % 4));
    run_stim();
    for (int i = 0; i < expQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i]) $display("FAIL store cyc%0d got=%b exp=%b", i, obsQ[i], expQ[i]);
      else nPass++;
    end
  endtask

  task automatic test_halt();
    expQ.delete();
    push(1'b0, 1'b0, rb(), junk(), mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    push(1'b1, 1'b0, rb(), junk(), mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    push(1'b1, 1'b0, rb(), junk(), mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    push(1'b1, 1'b1, rb(), junk(), mk(1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    add_body(T_R, 0);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, rb(), rb(), junk(), 12'd0);
    end
    push(1'b0, 1'b1, rb(), junk(), mk(1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    add_body(T_I, 0);
    run_stim();
    for (int i = 0; i < expQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i]) $display("FAIL halt cyc%0d got=%b exp=%b", i, obsQ[i], expQ[i]);
      else nPass++;
    end
  endtask

  task automatic test_random_mix();
    logic [31:0] eIns;
    logic [31:0] eCyc;
    expQ.delete();
    for (int n = 0; n < 30; n++) begin
      add_instr(randOp(), int'($urandom % 4), int'($urandom % 4));
    end
    run_stim();
    for (int i = 0; i < expQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i]) $display("FAIL mix cyc%0d got=%b exp=%b", i, obsQ[i], expQ[i]);
      else nPass++;
    end
`ifdef CTRL_PERF_CNT_EN
    eIns = 32'(expInstret);
    eCyc = 32'(expCycles);
`else
    eIns = 32'd0;
    eCyc = 32'd0;
`endif
    nChecks++;
    if (bus.instret_cnt !== eIns) $display("FAIL mix_instret got=%0d exp=%0d", bus.instret_cnt, eIns);
    else nPass++;
    nChecks++;
    if (bus.cycle_cnt !== eCyc) $display("FAIL mix_cycles got=%0d exp=%0d", bus.cycle_cnt, eCyc);
    else nPass++;
  endtask

  task automatic test_perf();
    logic [31:0] eIns;
    logic [31:0] eCyc;
    do_reset();
    add_instr(T_R, 0, 0);
    add_instr(T_R, 0, 0);
    add_instr(T_LOAD, 0, 0);
    run_stim();
    for (int i = 0; i < expQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i]) $display("FAIL perf_seq cyc%0d got=%b exp=%b", i, obsQ[i], expQ[i]);
      else nPass++;
    end
`ifdef CTRL_PERF_CNT_EN
    eIns = 32'd3;
    eCyc = 32'd13;
`else
    eIns = 32'd0;
    eCyc = 32'd0;
`endif
    nChecks++;
    if (bus.instret_cnt !== eIns) $display("FAIL perf_instret got=%0d exp=%0d", bus.instret_cnt, eIns);
    else nPass++;
    nChecks++;
    if (bus.cycle_cnt !== eCyc) $display("FAIL perf_cycles got=%0d exp=%0d", bus.cycle_cnt, eCyc);
    else nPass++;
  endtask

  task automatic test_illegal();
    expQ.delete();
    add_fetch(int'($urandom % 3));
    push(rb(), rb(), rb(), T_SYS, 12'd0);
    for (int i = 0; i < 20; i++) begin
      push(1'b0, rb(), rb(), junk(), mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1));
    end
    run_stim();
    for (int i = 0; i < expQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i]) $display("FAIL illegal cyc%0d got=%b exp=%b", i, obsQ[i], expQ[i]);
      else nPass++;
    end
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (bus.illegal_op !== 1'b0) $display("FAIL illegal_clear got=%b exp=0", bus.illegal_op);
    else nPass++;
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    expQ.delete();
    add_fetch(0);
    push(1'b0, 1'b0, 1'b0, T_LOAD, 12'd0);
    push(1'b0, 1'b0, 1'b0, junk(), mk(0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, junk(), mk(0, 0, 0, 1, 2'b01, 1, 0, 0, 0, 1, 0));
    push(1'b0, 1'b0, 1'b0, junk(), mk(0, 0, 0, 1, 2'b01, 1, 0, 0, 0, 1, 0));
    run_stim();
    for (int i = 0; i < expQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i]) $display("FAIL midmem cyc%0d got=%b exp=%b", i, obsQ[i], expQ[i]);
      else nPass++;
    end
    bus.dmem_ready = 1'b0;
    #1;
    nChecks++;
    if ({bus.dmem_req, bus.MemRead} !== 2'b11)
      $display("FAIL midmem_active got=%b exp=11", {bus.dmem_req, bus.MemRead});
    else nPass++;
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (sample() !== 12'd0) $display("FAIL midmem_async got=%b exp=%b", sample(), 12'd0);
    else nPass++;
    do_reset();
    add_instr(T_R, 0, 0);
    run_stim();
    for (int i = 0; i < expQ.size(); i++) begin
      nChecks++;
      if (obsQ[i] !== expQ[i]) $display("FAIL restart cyc%0d got=%b exp=%b", i, obsQ[i], expQ[i]);
      else nPass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    nChecks = 0;
    nPass = 0;
    expCycles = 0;
    expInstret = 0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_halt();
    test_random_mix();
    test_perf();
    test_illegal();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
